// File: rtl/comparator_sweep_pkg.sv
// Shared types and helpers for the exhaustive comparator sweep.
package comparator_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/comparator_sweep_counter.sv
// Operand-pair index {A,B} for the sweep; saturates at the final pair.
module sweep_counter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         incr,
  output logic [N-1:0] index,
  output logic         last
);

  assign last = &index;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (incr && !last) begin
      index <= index + 1'b1;
    end
  end

endmodule

// File: rtl/comparator_sweep.sv
// Exhaustive A/B sweep of an external comparator, streaming (A, B, Out) records.
// Optional golden check enabled by defining SWEEP_GOLDEN_EN.
module comparator_sweep
  import comparator_sweep_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE        = 1,
  parameter int unsigned GOLDEN_SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             cmp_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             res_bit,
  output logic [2*WIDTH:0] ones_count
`ifdef SWEEP_GOLDEN_EN
  ,
  output logic [2*WIDTH:0] err_count,
  output logic             mismatch
`endif
);

  localparam int unsigned IW  = 2 * WIDTH;
  localparam int unsigned OCW = 2 * WIDTH + 1;
  localparam int unsigned CW  = clog2(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [IW-1:0]   index;
  logic            idx_last;
  logic            idx_clear;
  logic            idx_incr;
  logic            accept_start;
  logic            handshake;

  assign accept_start = (state == ST_IDLE) && start;
  assign handshake    = (state == ST_EMIT) && res_valid && res_ready;
  assign idx_clear    = accept_start;
  assign idx_incr     = handshake;

  sweep_counter #(
    .N (IW)
  ) u_index (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (idx_clear),
    .incr    (idx_incr),
    .index   (index),
    .last    (idx_last)
  );

  // Operands come straight off the index register, so they hold the final pair in IDLE.
  assign a_out = index[IW-1:WIDTH];
  assign b_out = index[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_valid  <= 1'b0;
      res_bit    <= 1'b0;
      res_a      <= '0;
      res_b      <= '0;
      ones_count <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_DRIVE;
            busy       <= 1'b1;
            ones_count <= '0;
            settle_cnt <= '0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          res_bit    <= cmp_in;
          res_a      <= a_out;
          res_b      <= b_out;
          ones_count <= ones_count + OCW'(cmp_in);
          res_valid  <= 1'b1;
          state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            settle_cnt <= '0;
            if (idx_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SWEEP_GOLDEN_EN
  logic golden;

  always_comb begin
    golden = 1'b0;
    if (GOLDEN_SIGNED != 0) golden = $signed(a_out) > $signed(b_out);
    else                    golden = a_out > b_out;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= '0;
      mismatch  <= 1'b0;
    end else if (accept_start) begin
      err_count <= '0;
      mismatch  <= 1'b0;
    end else if ((state == ST_SAMPLE) && (cmp_in != golden)) begin
      err_count <= err_count + 1'b1;
      mismatch  <= 1'b1;
    end
  end
`endif

  a_record_held: assert property (@(posedge clk) disable iff (!reset_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_a) && $stable(res_b) && $stable(res_bit)));

  a_emit_valid: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ST_EMIT) |-> res_valid);

  a_done_busy: assert property (@(posedge clk) disable iff (!reset_n)
    done |-> busy);

endmodule

// File: tb/tb_comparator_sweep.sv
// Bench for comparator_sweep: two instances (SETTLE=1 and SETTLE=3) against a record-sequence model.
module tb_comparator_sweep;

  localparam int W  = 4;
  localparam int NP = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_n;
  logic fault_en, signed_mode, rand_ready;

  logic start0, ready0, cmp0, busy0, done0, valid0, bit0;
  logic [W-1:0] a0, b0, ra0, rb0;
  logic [2*W:0] ones0;
  logic start1, ready1, cmp1, busy1, done1, valid1, bit1;
  logic [W-1:0] a1, b1, ra1, rb1;
  logic [2*W:0] ones1;
`ifdef SWEEP_GOLDEN_EN
  logic [2*W:0] err0, err1;
  logic mm0, mm1;
`endif

  // Comparator under test for instance 0, with optional stuck-at-0 fault on (7,8).
  assign cmp0 = (fault_en && a0 == 4'd7 && b0 == 4'd8) ? 1'b0 :
                (signed_mode ? ($signed(a0) > $signed(b0)) : (a0 > b0));

  // Instance 1 sees a comparator whose output lags its inputs by two cycles.
  logic d1, d2;
  always @(posedge clk) begin
    d1 <= (a1 > b1);
    d2 <= d1;
  end
  assign cmp1 = d2;

  comparator_sweep #(.WIDTH(W), .SETTLE(1), .GOLDEN_SIGNED(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .done(done0),
    .a_out(a0), .b_out(b0), .cmp_in(cmp0), .res_valid(valid0), .res_ready(ready0),
    .res_a(ra0), .res_b(rb0), .res_bit(bit0), .ones_count(ones0)
`ifdef SWEEP_GOLDEN_EN
    , .err_count(err0), .mismatch(mm0)
`endif
  );

  comparator_sweep #(.WIDTH(W), .SETTLE(3), .GOLDEN_SIGNED(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
    .a_out(a1), .b_out(b1), .cmp_in(cmp1), .res_valid(valid1), .res_ready(ready1),
    .res_a(ra1), .res_b(rb1), .res_bit(bit1), .ones_count(ones1)
`ifdef SWEEP_GOLDEN_EN
    , .err_count(err1), .mismatch(mm1)
`endif
  );

  int checks = 0;
  int failures = 0;

  int rec[2], ones_m[2], done_seen[2], done_cyc[2], t_start[2];
  logic pv[2], pr[2], pbit[2];
  logic [W-1:0] pa[2], pb[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected comparator output for the idx-th pair, from plain integer arithmetic.
  function automatic int exp_bit(input int id, input int idx);
    int a, b, sa, sb;
    a = idx / 16;
    b = idx % 16;
    if (id == 1) return (a > b) ? 1 : 0;
    if (fault_en && a == 7 && b == 8) return 0;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (signed_mode) return (sa > sb) ? 1 : 0;
    return (a > b) ? 1 : 0;
  endfunction

  task automatic check_dut(input int id, input logic v, input logic r,
                           input logic [W-1:0] ao, input logic [W-1:0] bo,
                           input logic [W-1:0] ra, input logic [W-1:0] rb,
                           input logic rbit, input logic [2*W:0] oc,
                           input logic dn, input logic bs);
    int eb;
    if (v) begin
      check("a_out_matches_record", int'(ao), int'(ra));
      check("b_out_matches_record", int'(bo), int'(rb));
      check("busy_while_valid", int'(bs), 1);
    end
    if (pv[id] && !pr[id]) begin
      check("valid_held", int'(v), 1);
      check("res_a_held", int'(ra), int'(pa[id]));
      check("res_b_held", int'(rb), int'(pb[id]));
      check("res_bit_held", int'(rbit), int'(pbit[id]));
    end
    if (v && r) begin
      if (rec[id] >= NP) begin
        check("extra_record", rec[id], NP - 1);
      end else begin
        eb = exp_bit(id, rec[id]);
        check("rec_a", int'(ra), rec[id] / 16);
        check("rec_b", int'(rb), rec[id] % 16);
        check("rec_bit", int'(rbit), eb);
        ones_m[id] += eb;
        check("ones_running", int'(oc), ones_m[id]);
        rec[id]++;
      end
    end
    if (dn) begin
      check("done_after_all_records", rec[id], NP);
      done_seen[id]++;
      done_cyc[id] = cyc;
    end
    pv[id] = v;
    pr[id] = r;
    pa[id] = ra;
    pb[id] = rb;
    pbit[id] = rbit;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
      end else begin
        check_dut(0, valid0, ready0, a0, b0, ra0, rb0, bit0, ones0, done0, busy0);
        check_dut(1, valid1, ready1, a1, b1, ra1, rb1, bit1, ones1, done1, busy1);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_sweep(input int id);
    rec[id] = 0;
    ones_m[id] = 0;
    done_seen[id] = 0;
    pv[id] = 1'b0;
    if (id == 0) start0 = 1'b1;
    else         start1 = 1'b1;
    cycles(1);
    start0 = 1'b0;
    start1 = 1'b0;
    t_start[id] = cyc;
  endtask

  task automatic wait_done(input int id, input int budget);
    int n;
    n = 0;
    while (done_seen[id] == 0 && n < budget) begin
      cycles(1);
      if (id == 0 && rand_ready) ready0 = ($urandom_range(0, 99) < 30);
      n++;
    end
    check("done_timeout", done_seen[id], 1);
    ready0 = 1'b1;
    cycles(2);
    check("done_single_pulse", done_seen[id], 1);
    check("busy_low_after_done", int'(id == 0 ? busy0 : busy1), 0);
  endtask

  task automatic wait_records(input int id, input int target, input int budget);
    int n;
    n = 0;
    while (rec[id] < target && n < budget) begin
      cycles(1);
      n++;
    end
    check("record_wait_timeout", int'(rec[id] >= target), 1);
  endtask

  task automatic check_reset_state();
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_valid", int'(valid0), 0);
    check("rst_bit", int'(bit0), 0);
    check("rst_a_out", int'(a0), 0);
    check("rst_b_out", int'(b0), 0);
    check("rst_res_a", int'(ra0), 0);
    check("rst_res_b", int'(rb0), 0);
    check("rst_ones", int'(ones0), 0);
`ifdef SWEEP_GOLDEN_EN
    check("rst_err_count", int'(err0), 0);
    check("rst_mismatch", int'(mm0), 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1;
    fault_en = 1'b0; signed_mode = 1'b0; rand_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rec[i] = 0; ones_m[i] = 0; done_seen[i] = 0; done_cyc[i] = 0; t_start[i] = 0;
      pv[i] = 1'b0; pr[i] = 1'b0; pbit[i] = 1'b0; pa[i] = '0; pb[i] = '0;
    end
    fork
      monitor_loop();
    join_none
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    check_reset_state();

    // Full sweep, no back-pressure.
    start_sweep(0);
    wait_done(0, 2000);
    check("full_latency", done_cyc[0] - t_start[0] + 1, 769);
    check("full_ones", int'(ones0), 120);
    check("full_records", rec[0], 256);
    check("final_a_held", int'(a0), 15);
    check("final_b_held", int'(b0), 15);

    // Random 30% back-pressure.
    rand_ready = 1'b1;
    start_sweep(0);
    wait_done(0, 20000);
    rand_ready = 1'b0;
    check("bp_ones", int'(ones0), 120);
    check("bp_records", rec[0], 256);

    // Start pulse mid-sweep must be ignored.
    start_sweep(0);
    wait_records(0, 37, 500);
    start0 = 1'b1;
    cycles(1);
    start0 = 1'b0;
    wait_done(0, 2000);
    check("busy_start_records", rec[0], 256);
    check("busy_start_latency", done_cyc[0] - t_start[0] + 1, 769);

    // Reset mid-sweep, with a start coinciding with the last reset cycle.
    start_sweep(0);
    wait_records(0, 100, 1000);
    reset_n = 1'b0;
    cycles(2);
    start0 = 1'b1;
    cycles(1);
    reset_n = 1'b1;
    start0 = 1'b0;
    check_reset_state();
    cycles(3);
    check("start_in_reset_ignored", int'(busy0), 0);
    start_sweep(0);
    check("restart_a", int'(a0), 0);
    check("restart_b", int'(b0), 0);
    wait_done(0, 2000);
    check("restart_latency", done_cyc[0] - t_start[0] + 1, 769);
    check("restart_ones", int'(ones0), 120);

    // SETTLE=3 against a two-cycle-late comparator.
    start_sweep(1);
    wait_done(1, 3000);
    check("settle_latency", done_cyc[1] - t_start[1] + 1, 1281);
    check("settle_ones", int'(ones1), 120);
    check("settle_records", rec[1], 256);

`ifdef SWEEP_GOLDEN_EN
    signed_mode = 1'b1;
    fault_en = 1'b1;
    start_sweep(0);
    wait_done(0, 2000);
    check("golden_fault_err", int'(err0), 1);
    check("golden_fault_mismatch", int'(mm0), 1);
    check("golden_fault_ones", int'(ones0), 119);
    fault_en = 1'b0;
    start_sweep(0);
    wait_done(0, 2000);
    check("golden_clean_err", int'(err0), 0);
    check("golden_clean_mismatch", int'(mm0), 0);
    check("golden_clean_ones", int'(ones0), 120);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
